// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory arbiter: line/word widths, arbiter FSM
// states and requester identifiers.
package lc3b_types;

   localparam int LC3B_ADDR_W = 16;
   localparam int LC3B_LINE_W = 128;

   typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
   typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_SERVE_I,
      ARB_SERVE_D,
      ARB_DONE
   } arb_state_t;

   typedef enum logic {
      ARB_REQ_I,
      ARB_REQ_D
   } arb_req_t;

endpackage

// File: rtl/lc3b_arb_select.sv
// Combinational grant selection between the I-cache and D-cache requests.
// ARB_FAIR_EN selects round-robin on contention; otherwise the D-cache always wins.
module lc3b_arb_select
   import lc3b_types::*;
(
   input  logic     i_req,
   input  logic     d_req,
   input  arb_req_t last_grant,
   output logic     grant_valid,
   output arb_req_t grant
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      grant_valid = i_req | d_req;
      grant       = ARB_REQ_D;
`ifdef ARB_FAIR_EN
      if (i_req && (!d_req || last_grant == ARB_REQ_D)) begin
         grant = ARB_REQ_I;
      end
`else
      if (i_req && !d_req) begin
         grant = ARB_REQ_I;
      end
`endif
   end

`ifndef ARB_FAIR_EN
   // Fixed priority never consults the previous grant.
   logic unused_last_grant;
   assign unused_last_grant = (last_grant == ARB_REQ_D);
`endif

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Shares one physical-memory line port between the I-cache and the D-cache.
// Define ARB_FAIR_EN for round-robin on contention; default build gives the D-cache fixed priority.
module lc3b_mem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_W = LC3B_ADDR_W,
   parameter int LINE_W = LC3B_LINE_W
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              icache_read,
   input  logic [ADDR_W-1:0] icache_address,
   output logic [LINE_W-1:0] icache_rdata,
   output logic              icache_resp,

   input  logic              dcache_read,
   input  logic              dcache_write,
   input  logic [ADDR_W-1:0] dcache_address,
   input  logic [LINE_W-1:0] dcache_wdata,
   output logic [LINE_W-1:0] dcache_rdata,
   output logic              dcache_resp,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t state;
   arb_state_t state_next;
   logic       d_req;
   logic       grant_valid;
   arb_req_t   grant;
   arb_req_t   last_grant;

   // A simultaneous read and write from the D-cache is served as a write.
   assign d_req = dcache_read | dcache_write;

   lc3b_arb_select u_select (
      .i_req       (icache_read),
      .d_req       (d_req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

`ifdef ARB_FAIR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= ARB_REQ_D;
      end else if (state == ARB_IDLE && grant_valid) begin
         last_grant <= grant;
      end
   end
`else
   assign last_grant = ARB_REQ_D;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ARB_IDLE: begin
            if (grant_valid) begin
               state_next = (grant == ARB_REQ_D) ? ARB_SERVE_D : ARB_SERVE_I;
            end
         end
         ARB_SERVE_I,
         ARB_SERVE_D: begin
            if (pmem_resp) begin
               state_next = ARB_DONE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // Output registers: the latched request is driven to pmem until its response.
   always_ff @(posedge clk) begin
      if (reset) begin
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
         icache_rdata <= '0;
         icache_resp  <= 1'b0;
         dcache_rdata <= '0;
         dcache_resp  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         icache_resp <= 1'b0;
         dcache_resp <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant_valid) begin
                  if (grant == ARB_REQ_D) begin
                     pmem_address <= dcache_address;
                     pmem_wdata   <= dcache_wdata;
                     pmem_write   <= dcache_write;
                     pmem_read    <= ~dcache_write;
                  end else begin
                     pmem_address <= icache_address;
                     pmem_wdata   <= '0;
                     pmem_write   <= 1'b0;
                     pmem_read    <= 1'b1;
                  end
               end
            end
            ARB_SERVE_I: begin
               if (pmem_resp) begin
                  icache_rdata <= pmem_rdata;
                  icache_resp  <= 1'b1;
                  pmem_read    <= 1'b0;
                  pmem_write   <= 1'b0;
               end
            end
            ARB_SERVE_D: begin
               if (pmem_resp) begin
                  dcache_rdata <= pmem_rdata;
                  dcache_resp  <= 1'b1;
                  pmem_read    <= 1'b0;
                  pmem_write   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
